// File: rtl/ascon_hash_arbiter_if.sv
// Bus bundle between two hash requesters, the arbiter and a shared Ascon hash core.
// The slave modport is the arbiter's view; master is the requester/core side.
interface ascon_hash_arbiter_if #(
    parameter int Y = 256,
    parameter int L = 256
);
    logic [1:0]   req;
    logic [Y-1:0] msg0;
    logic [Y-1:0] msg1;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic [1:0]   err;
    logic [1:0]   ack;
    logic [L-1:0] digest;
    logic [Y-1:0] core_msg;
    logic         core_start;
    logic         core_ready;
    logic [L-1:0] core_digest;

    modport slave (
        input  req, msg0, msg1, ack, core_ready, core_digest,
        output gnt, done, err, digest, core_msg, core_start
    );

    modport master (
        output req, msg0, msg1, ack, core_ready, core_digest,
        input  gnt, done, err, digest, core_msg, core_start
    );
endinterface

// File: rtl/ascon_hash_arbiter.sv
// Round-robin arbiter sharing one Ascon hash core between two requesters.
// Optional abort-on-timeout is enabled by defining HASH_ARB_TIMEOUT_EN.
module ascon_hash_arbiter #(
    parameter int Y       = 256,
    parameter int L       = 256,
    parameter int TIMEOUT = 1024
) (
    input logic                clk,
    input logic                rst,
    ascon_hash_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [1:0]   done_q, done_d;
    logic [L-1:0] digest_q, digest_d;
    logic [Y-1:0] core_msg_q, core_msg_d;
    logic         core_start_q, core_start_d;
    logic         last_q, last_d;
    logic         win;
    logic [1:0]   ack_hit;

`ifdef HASH_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  err_q, err_d;
`endif

    // Only an ack from the requester that currently holds the grant releases the core.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign ack_hit[gi] = bus.ack[gi] & gnt_q[gi];
    end

    always_comb begin
        win = 1'b0;
        if (bus.req == 2'b11) begin
            win = ~last_q;
        end else begin
            win = bus.req[1];
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        done_d       = done_q;
        digest_d     = digest_q;
        core_msg_d   = core_msg_q;
        core_start_d = 1'b0;
        last_d       = last_q;
`ifdef HASH_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 2'b00;
`endif
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    gnt_d      = 2'b01 << win;
                    core_msg_d = win ? bus.msg1 : bus.msg0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                core_start_d = 1'b1;
                state_d      = S_ARM;
`ifdef HASH_ARB_TIMEOUT_EN
                cnt_d        = 16'd0;
`endif
            end
            // A ready level left over from the previous job must be seen low first.
            S_ARM: begin
                if (!bus.core_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.core_ready) begin
                    digest_d = bus.core_digest;
                    done_d   = gnt_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (|ack_hit) begin
                    done_d  = 2'b00;
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef HASH_ARB_TIMEOUT_EN
        // A digest arriving in WAIT takes precedence over the timeout on the same edge.
        if (state_q == S_ARM || (state_q == S_WAIT && !bus.core_ready)) begin
            if (cnt_q == TIMEOUT_LIM) begin
                err_d   = gnt_q;
                gnt_d   = 2'b00;
                last_d  = gnt_q[1];
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            digest_q     <= '0;
            core_msg_q   <= '0;
            core_start_q <= 1'b0;
            last_q       <= 1'b1;
`ifdef HASH_ARB_TIMEOUT_EN
            cnt_q        <= 16'd0;
            err_q        <= 2'b00;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            digest_q     <= digest_d;
            core_msg_q   <= core_msg_d;
            core_start_q <= core_start_d;
            last_q       <= last_d;
`ifdef HASH_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.digest     = digest_q;
    assign bus.core_msg   = core_msg_q;
    assign bus.core_start = core_start_q;
`ifdef HASH_ARB_TIMEOUT_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 2'b00;
`endif

endmodule
